// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } requester_e;

    // On a conflict the requester that did not win last time gets the grant.
    function automatic requester_e pick_requester(input logic if_req,
                                                  input logic dm_req,
                                                  input requester_e last);
        requester_e pick;
        if (if_req && dm_req) begin
            pick = (last == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (dm_req) begin
            pick = REQ_DM;
        end else begin
            pick = REQ_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory-ack watchdog: counts busy cycles and flags the last allowed one.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [9:0] LAST_CNT = 10'(LIMIT - 1);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    // Next count: clear dominates, otherwise advance while counting, stop at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 10'd0;
        end else if (count && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 10'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 10'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged during the LIMIT-th counted cycle.
    assign expired = count && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single unified memory port.
// One memory transaction outstanding at a time; fair alternation on conflicts.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_done,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [BE_W-1:0] dm_be,
    output logic            dm_done,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES out of range 1..1023");
    end

    arb_state_e      state_q, state_d;
    requester_e      last_q, last_d;
    requester_e      pick_s;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0] mem_be_q, mem_be_d;
    logic            if_done_q, if_done_d;
    logic            dm_done_q, dm_done_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic [XLEN-1:0] resp_data_s;
    logic            wd_expired_s;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_count_s;
    logic wd_clear_s;
    logic err_q;

    assign wd_count_s = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign wd_clear_s = !wd_count_s;

    mem_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_s),
        .count   (wd_count_s),
        .expired (wd_expired_s)
    );

    // Error flag: set only for a busy cycle that expires without an ack, so it coincides with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wd_count_s && !mem_ack && wd_expired_s;
        end
    end

    assign err = err_q;
`else
    assign wd_expired_s = 1'b0;
    assign err          = 1'b0;
`endif

    assign pick_s = pick_requester(if_req, dm_req, last_q);

    // Next-state and output logic: grant in IDLE, wait for ack (or expiry) in BUSY, pulse done in RESP.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        resp_data_s = '0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    last_d    = pick_s;
                    mem_req_d = 1'b1;
                    if (pick_s == REQ_DM) begin
                        state_d     = BUSY_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end else begin
                        state_d     = BUSY_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An ack in the expiry cycle is a normal completion.
                if (mem_ack || wd_expired_s) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_ack && !mem_we_q) begin
                        resp_data_s = mem_rdata;
                    end else begin
                        resp_data_s = '0;
                    end
                    if (state_q == BUSY_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = resp_data_s;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = resp_data_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= REQ_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
